// File: rtl/intt_butterfly_pipe_if.sv
// Handshake bundle for the inverse-NTT butterfly: input triple plus result pair.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the input and the output side.
interface intt_butterfly_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] twiddle;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;

    // Source of coefficients / sink of results
    modport master (
        output in_valid, a, b, twiddle, out_ready,
        input  in_ready, out_valid, a_out, b_out
    );

    // The butterfly itself
    modport slave (
        input  in_valid, a, b, twiddle, out_ready,
        output in_ready, out_valid, a_out, b_out
    );
endinterface

// File: rtl/intt_butterfly_pipe.sv
// Gentleman-Sande INTT butterfly: a'=(a+b)h mod q, b'=(a-b)*w*h mod q, h=1/2 optionally.
// Latency: 3 cycles (add/sub -> modular multiply -> halve), 1 result per cycle.
// Backpressure: whole pipeline stalls together when the output is held; in_ready is combinational.
module intt_butterfly_pipe #(
    parameter int          WIDTH          = 32,
    parameter int unsigned Q              = 8380417,
    parameter int          REDUCTION_TYPE = 0,
    parameter bit          HALVE          = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    intt_butterfly_pipe_if.slave  bus_if
);
    localparam int               PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] QW = WIDTH'(Q);
    localparam logic [PW-1:0]    QP = PW'(Q);

    // Barrett constant floor(2^(2*WIDTH) / Q)
    function automatic logic [PW:0] calc_mu();
        logic [PW:0] num;
        num     = '0;
        num[PW] = 1'b1;
        return num / (PW + 1)'(Q);
    endfunction

    // Montgomery constant -Q^-1 mod 2^WIDTH via Newton iteration (Q odd, so Q*Q == 1 mod 8)
    function automatic logic [WIDTH-1:0] calc_qneg();
        logic [WIDTH-1:0] inv;
        inv = QW;
        for (int i = 0; i < 6; i++) begin
            inv = inv * (WIDTH'(2) - QW * inv);
        end
        return WIDTH'(0) - inv;
    endfunction

    localparam logic [PW:0]      MU   = calc_mu();
    localparam logic [WIDTH-1:0] QNEG = calc_qneg();

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, QW}) s = s - {1'b0, QW};
        return s[WIDTH-1:0];
    endfunction

    // x + (Q - y) cannot overflow: it only runs when x < y < Q
    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return (x >= y) ? (x - y) : (x + (QW - y));
    endfunction

    // Product reduction; the Montgomery variant expects y pre-scaled by 2^WIDTH
    function automatic logic [WIDTH-1:0] mod_mult(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [PW-1:0]   t;
        logic [2*PW:0]   tm;
        logic [PW-1:0]   qh;
        logic [PW-1:0]   mm;
        logic [WIDTH-1:0] m;
        logic [PW-1:0]   r;
        t = PW'(x) * PW'(y);
        if (REDUCTION_TYPE == 1) begin
            // quotient estimate is at most 2 short, so r < 3Q before correction
            tm = (2 * PW + 1)'(t) * (2 * PW + 1)'(MU);
            qh = tm[2*PW-1:PW];
            r  = t - qh * QP;
            if (r >= QP) r = r - QP;
            if (r >= QP) r = r - QP;
        end else if (REDUCTION_TYPE == 2) begin
            // t + m*Q is a multiple of 2^WIDTH and below 2^(2*WIDTH), result < 2Q
            mm = PW'(t[WIDTH-1:0]) * PW'(QNEG);
            m  = mm[WIDTH-1:0];
            r  = (t + PW'(m) * QP) >> WIDTH;
            if (r >= QP) r = r - QP;
        end else begin
            r = t % QP;
        end
        return r[WIDTH-1:0];
    endfunction

    // Multiply by 2^-1 mod Q: odd values borrow one Q (Q odd makes x+Q even)
    function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] e;
        e = x[0] ? ({1'b0, x} + {1'b0, QW}) : {1'b0, x};
        return e[WIDTH:1];
    endfunction

    logic             v1_q, v2_q, v3_q;
    logic [WIDTH-1:0] s1_q, d1_q, w1_q;
    logic [WIDTH-1:0] s2_q, p2_q;
    logic [WIDTH-1:0] a3_q, b3_q;
    logic [WIDTH-1:0] s1_d, d1_d, p2_d, a3_d, b3_d;
    logic             adv;

    // Pipeline moves as one unit unless a finished result is waiting on the sink
    assign adv              = !v3_q || bus_if.out_ready;
    assign bus_if.in_ready  = adv && !rst;
    assign bus_if.out_valid = v3_q;
    assign bus_if.a_out     = a3_q;
    assign bus_if.b_out     = b3_q;

    // Per-stage arithmetic feeding the next register
    always_comb begin
        s1_d = mod_add(bus_if.a, bus_if.b);
        d1_d = mod_sub(bus_if.a, bus_if.b);
        p2_d = mod_mult(d1_q, w1_q);
        a3_d = HALVE ? halve(s2_q) : s2_q;
        b3_d = HALVE ? halve(p2_q) : p2_q;
    end

    // Stage registers: reset clears everything, stall holds everything, bubbles shift like data
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s1_q <= '0;
            d1_q <= '0;
            w1_q <= '0;
            s2_q <= '0;
            p2_q <= '0;
            a3_q <= '0;
            b3_q <= '0;
        end else if (adv) begin
            v1_q <= bus_if.in_valid;
            s1_q <= s1_d;
            d1_q <= d1_d;
            w1_q <= bus_if.twiddle;
            v2_q <= v1_q;
            s2_q <= s1_q;
            p2_q <= p2_d;
            v3_q <= v2_q;
            a3_q <= a3_d;
            b3_q <= b3_d;
        end
    end
endmodule

// File: tb/tb_intt_butterfly_pipe.sv
// Bench for intt_butterfly_pipe: four instances (no halving, and halving with each reduction type).
// Latency: checks 3-cycle input-to-output timing and 1/cycle streaming.
// Backpressure: exercises random out_ready stalls and a mid-flight reset.
module tb_intt_butterfly_pipe;
    localparam int              W  = 32;
    localparam longint unsigned QL = 64'd8380417;

    typedef struct {
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [W-1:0]    w;
        longint unsigned ea0;  // a_out, no halving
        longint unsigned eb0;  // b_out, no halving
        longint unsigned ea1;  // a_out, halved
        longint unsigned eb1;  // b_out, halved
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a_d, b_d, w_d;
    int           n_checks = 0;
    int           n_fail   = 0;
    vec_t         tbl[8];
    logic [W-1:0] sa[16], sb[16], sw[16];

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_mont(input logic [W-1:0] w);
        longint unsigned t;
        t = longint'(w) << 32;
        return W'(t % QL);
    endfunction

    function automatic longint unsigned m_half(input longint unsigned x);
        return (x % 2 == 1) ? (x + QL) / 2 : x / 2;
    endfunction

    function automatic longint unsigned ref_s(input longint unsigned a, input longint unsigned b);
        return (a + b) % QL;
    endfunction

    function automatic longint unsigned ref_p(input longint unsigned a, input longint unsigned b,
                                              input longint unsigned w);
        return (((a + QL - b) % QL) * w) % QL;
    endfunction

    intt_butterfly_pipe_if #(.WIDTH(W)) bus_h0 ();
    intt_butterfly_pipe_if #(.WIDTH(W)) bus_s ();
    intt_butterfly_pipe_if #(.WIDTH(W)) bus_b ();
    intt_butterfly_pipe_if #(.WIDTH(W)) bus_m ();

    assign bus_h0.in_valid = in_valid;
    assign bus_h0.a        = a_d;
    assign bus_h0.b        = b_d;
    assign bus_h0.twiddle  = w_d;
    assign bus_h0.out_ready = out_ready;
    assign bus_s.in_valid  = in_valid;
    assign bus_s.a         = a_d;
    assign bus_s.b         = b_d;
    assign bus_s.twiddle   = w_d;
    assign bus_s.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.a         = a_d;
    assign bus_b.b         = b_d;
    assign bus_b.twiddle   = w_d;
    assign bus_b.out_ready = out_ready;
    assign bus_m.in_valid  = in_valid;
    assign bus_m.a         = a_d;
    assign bus_m.b         = b_d;
    assign bus_m.twiddle   = to_mont(w_d);
    assign bus_m.out_ready = out_ready;

    intt_butterfly_pipe #(.WIDTH(W), .Q(8380417), .REDUCTION_TYPE(0), .HALVE(1'b0))
        u_h0 (.clk(clk), .rst(rst), .bus_if(bus_h0));
    intt_butterfly_pipe #(.WIDTH(W), .Q(8380417), .REDUCTION_TYPE(0), .HALVE(1'b1))
        u_s  (.clk(clk), .rst(rst), .bus_if(bus_s));
    intt_butterfly_pipe #(.WIDTH(W), .Q(8380417), .REDUCTION_TYPE(1), .HALVE(1'b1))
        u_b  (.clk(clk), .rst(rst), .bus_if(bus_b));
    intt_butterfly_pipe #(.WIDTH(W), .Q(8380417), .REDUCTION_TYPE(2), .HALVE(1'b1))
        u_m  (.clk(clk), .rst(rst), .bus_if(bus_m));

    task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input longint unsigned ea0, input longint unsigned eb0,
                              input longint unsigned ea1, input longint unsigned eb1);
        chk({tag, "_h0_valid"}, bus_h0.out_valid, 1);
        chk({tag, "_bar_valid"}, bus_b.out_valid, 1);
        chk({tag, "_mont_valid"}, bus_m.out_valid, 1);
        chk({tag, "_h0_a"}, bus_h0.a_out, ea0);
        chk({tag, "_h0_b"}, bus_h0.b_out, eb0);
        chk({tag, "_simple_a"}, bus_s.a_out, ea1);
        chk({tag, "_simple_b"}, bus_s.b_out, eb1);
        chk({tag, "_bar_a"}, bus_b.a_out, ea1);
        chk({tag, "_bar_b"}, bus_b.b_out, eb1);
        chk({tag, "_mont_a"}, bus_m.a_out, ea1);
        chk({tag, "_mont_b"}, bus_m.b_out, eb1);
    endtask

    // Present one triple for exactly one cycle, then measure cycles until out_valid
    task automatic one_shot(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] w, input longint unsigned ea0, input longint unsigned eb0,
                            input longint unsigned ea1, input longint unsigned eb1);
        int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_d = a;
        b_d = b;
        w_d = w;
        #1;
        chk({tag, "_in_ready"}, bus_s.in_ready, 1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end while (!bus_s.out_valid && lat < 10);
        chk({tag, "_latency"}, lat, 3);
        check_outs(tag, ea0, eb0, ea1, eb1);
    endtask

    // Push the 16-entry stream; sink ready is either constant or pseudo-random
    task automatic run_stream(input string tag, input bit toggle);
        int           sent = 0;
        int           got = 0;
        int           cyc = 0;
        int           first_emit = -1;
        int           last_emit = -1;
        bit           stalled = 1'b0;
        logic [W-1:0] ha0, hb0, ha1, hb1;
        longint unsigned rs, rp;
        while (got < 16 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            out_ready = toggle ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (sent < 16) begin
                in_valid = 1'b1;
                a_d = sa[sent];
                b_d = sb[sent];
                w_d = sw[sent];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (stalled) begin
                chk({tag, "_hold_valid"}, bus_s.out_valid, 1);
                chk({tag, "_hold_h0_a"}, bus_h0.a_out, ha0);
                chk({tag, "_hold_h0_b"}, bus_h0.b_out, hb0);
                chk({tag, "_hold_a"}, bus_s.a_out, ha1);
                chk({tag, "_hold_b"}, bus_s.b_out, hb1);
            end
            chk({tag, "_in_ready"}, bus_s.in_ready, !bus_s.out_valid || out_ready);
            if (bus_s.out_valid && out_ready) begin
                rs = ref_s(sa[got], sb[got]);
                rp = ref_p(sa[got], sb[got], sw[got]);
                check_outs($sformatf("%s_res%0d", tag, got), rs, rp, m_half(rs), m_half(rp));
                if (first_emit < 0) first_emit = cyc;
                last_emit = cyc;
                got++;
            end
            stalled = bus_s.out_valid && !out_ready;
            ha0 = bus_h0.a_out;
            hb0 = bus_h0.b_out;
            ha1 = bus_s.a_out;
            hb1 = bus_s.b_out;
            if (in_valid && bus_s.in_ready) sent++;
        end
        chk({tag, "_count"}, got, 16);
        if (!toggle) chk({tag, "_consecutive"}, last_emit - first_emit, 15);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk({tag, "_no_extra"}, bus_s.out_valid, 0);
        end
    endtask

    initial begin
        tbl[0] = '{32'd5, 32'd3, 32'd1, 8, 2, 4, 1};
        tbl[1] = '{32'd3, 32'd5, 32'd1, 8, 8380415, 4, 8380416};
        tbl[2] = '{32'd0, 32'd1, 32'd2, 1, 8380415, 4190209, 8380416};
        tbl[3] = '{32'd8380416, 32'd8380416, 32'd7, 8380415, 0, 8380416, 0};
        tbl[4] = '{32'd0, 32'd0, 32'd5, 0, 0, 0, 0};
        tbl[5] = '{32'd1, 32'd0, 32'd3, 1, 3, 4190209, 4190210};
        tbl[6] = '{32'd100, 32'd40, 32'd1000, 140, 60000, 70, 30000};
        tbl[7] = '{32'd8380416, 32'd0, 32'd8380416, 8380416, 1, 4190208, 4190209};
        for (int i = 0; i < 16; i++) begin
            sa[i] = W'($urandom % 32'd8380417);
            sb[i] = W'($urandom % 32'd8380417);
            sw[i] = W'($urandom % 32'd8380417);
        end

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_d = '0;
        b_d = '0;
        w_d = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", bus_s.in_ready, 0);
        chk("reset_out_valid", bus_s.out_valid, 0);
        chk("reset_h0_a", bus_h0.a_out, 0);
        chk("reset_h0_b", bus_h0.b_out, 0);
        chk("reset_mont_b", bus_m.b_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", bus_s.in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            one_shot($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].w,
                     tbl[i].ea0, tbl[i].eb0, tbl[i].ea1, tbl[i].eb1);
        end

        run_stream("stream", 1'b0);
        run_stream("stall", 1'b1);

        // Fill all three stages, then reset for one cycle
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_d = 32'd10; b_d = 32'd20; w_d = 32'd30;
        @(posedge clk); #1;
        a_d = 32'd11; b_d = 32'd21; w_d = 32'd31;
        @(posedge clk); #1;
        a_d = 32'd12; b_d = 32'd22; w_d = 32'd32;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("midrst_full", bus_s.out_valid, 1);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", bus_s.in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_h0_valid", bus_h0.out_valid, 0);
        chk("midrst_valid", bus_s.out_valid, 0);
        chk("midrst_a", bus_s.a_out, 0);
        repeat (5) begin
            @(posedge clk); #1;
            chk("midrst_no_stale", bus_s.out_valid | bus_h0.out_valid | bus_m.out_valid, 0);
        end
        one_shot("after_rst", 32'd100, 32'd40, 32'd1000, 140, 60000, 70, 30000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
